// File: rtl/mac_seq_pkg.sv
// Shared definitions for the 4-lane MAC sequencing controller.
package mac_seq_pkg;

  localparam int NLANE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dot4_tree.sv
// Combinational 4-lane dot product: unsigned x times signed w per lane,
// summed by a 2-level adder tree and sign-extended to psum_bw.
module dot4_tree
  import mac_seq_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic [NLANE*bw-1:0]       x,
  input  logic [NLANE*bw-1:0]       w,
  output logic signed [psum_bw-1:0] dot
);

  // Product width: zero-extended x (bw+1) times signed w (bw).
  localparam int pw = 2*bw + 1;

  logic signed [pw-1:0] xe   [NLANE];
  logic signed [pw-1:0] we   [NLANE];
  logic signed [pw-1:0] prod [NLANE];
  logic signed [pw:0]   s1   [2];
  logic signed [pw+1:0] s2;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    assign xe[i]   = {{(pw-bw){1'b0}}, x[i*bw +: bw]};
    assign we[i]   = {{(pw-bw){w[i*bw+bw-1]}}, w[i*bw +: bw]};
    assign prod[i] = xe[i] * we[i];
  end

  assign s1[0] = {prod[0][pw-1], prod[0]} + {prod[1][pw-1], prod[1]};
  assign s1[1] = {prod[2][pw-1], prod[2]} + {prod[3][pw-1], prod[3]};
  assign s2    = {s1[0][pw], s1[0]} + {s1[1][pw], s1[1]};
  assign dot   = {{(psum_bw-pw-2){s2[pw+1]}}, s2};

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller: accepts cfg_len chunks, accumulates their 4-lane
// dot products through a one-stage pipeline and returns one psum per run.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [len_bw-1:0]         cfg_len,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NLANE*bw-1:0]       x_in,
  input  logic [NLANE*bw-1:0]       w_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [psum_bw-1:0] out_data,
  output logic                      out_ovf,
  output logic [1:0]                fsm_state
);

  state_t                     state;
  logic [len_bw-1:0]          remaining;
  logic signed [psum_bw-1:0]  stage;
  logic                       stage_vld;
  logic signed [psum_bw-1:0]  acc;
  logic                       ovf;
  logic signed [psum_bw-1:0]  dot;
  logic signed [psum_bw-1:0]  acc_sum;
  logic                       add_ovf;
  logic                       in_hs;

  dot4_tree #(.bw(bw), .psum_bw(psum_bw)) u_tree (
    .x   (x_in),
    .w   (w_in),
    .dot (dot)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid may rise at any time, and once out_valid is up out_data
  // and out_ovf stay fixed until the transfer.
  assign in_hs   = in_valid & in_ready;
  assign acc_sum = acc + stage;
  assign add_ovf = (acc[psum_bw-1] == stage[psum_bw-1]) &&
                   (acc_sum[psum_bw-1] != acc[psum_bw-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      stage     <= '0;
      stage_vld <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      if (state != IDLE && stage_vld) begin
        acc <= acc_sum;
        if (add_ovf) ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          stage_vld <= 1'b0;
          if (start) begin
            remaining <= (cfg_len == '0) ? len_bw'(1) : cfg_len;
            acc       <= '0;
            ovf       <= 1'b0;
            state     <= ACC;
          end
        end
        ACC: begin
          stage_vld <= in_hs;
          if (in_hs) begin
            stage     <= dot;
            remaining <= remaining - len_bw'(1);
            if (remaining == len_bw'(1)) state <= FLUSH;
          end
        end
        // The last stage value is folded into acc during this cycle.
        FLUSH: begin
          stage_vld <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign out_ovf   = ovf;
  assign fsm_state = state;

endmodule
